lane_scheduler: RTL and testbench

- Central sequencer for the falling-note lanes (pattern instances) of the rhythm game.
- Collects per-lane "trocar" requests for a new command and grants them one at a time, round-robin.
- Fetches each granted command from the command-list ROM and loads it into the granted lane only.
- Accumulates the score from per-lane "ponto" pulses and raises end-of-game when the list is exhausted.
- Replaces the OR-ed trocar wiring and the posedge-ponto score counter at top level.

---
 rtl/game_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/lane_scheduler.sv | 166 ++++++++++++++++
 tb/tb_lane_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the rhythm-game sequencing blocks.
// Imported by the lane scheduler and its arbiter.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_FETCH,
    S_LOAD,
    S_DONE
  } state_e;

  localparam int DEF_CMD_W   = 4;
  localparam int DEF_SCORE_W = 8;

  localparam logic [DEF_CMD_W-1:0] CMD_NONE = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, with wrap.
// Emits a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_scheduler.sv
// Grants per-lane command requests round-robin, loads each lane from the
// command list, and keeps the game score until the list runs out.
module lane_scheduler
  import game_pkg::*;
#(
  parameter int N_LANES  = 3,
  parameter int CMD_W    = DEF_CMD_W,
  parameter int ADDR_W   = 4,
  parameter int LIST_LEN = 10,
  parameter int SCORE_W  = DEF_SCORE_W
) (
  input  logic               CLOCK_25,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_LANES-1:0] trocar_req,
  input  logic [N_LANES-1:0] ponto_in,
  output logic [ADDR_W-1:0]  cmd_addr,
  input  logic [CMD_W-1:0]   cmd_data,
  output logic [CMD_W-1:0]   cmd_out,
  output logic [N_LANES-1:0] cmd_load,
  output logic [SCORE_W-1:0] score,
  output logic               fim_de_jogo,
  output logic               busy
);

  localparam int IW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(LIST_LEN);

  state_e             state_q, state_d;
  logic [N_LANES-1:0] pending_q, pending_d;
  logic [N_LANES-1:0] prev_req_q, prev_req_d;
  logic [N_LANES-1:0] prev_ponto_q, prev_ponto_d;
  logic [N_LANES-1:0] cmd_load_q, cmd_load_d;
  logic [CMD_W-1:0]   cmd_out_q, cmd_out_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [ADDR_W-1:0]  list_ptr_q, list_ptr_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic               fim_q, fim_d;
  logic               busy_q, busy_d;

  logic [N_LANES-1:0] req_edge, ponto_edge;
  logic [N_LANES-1:0] arb_gnt, grant_mask;
  logic [IW-1:0]      arb_idx;
  logic               arb_vld;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [ADDR_W:0]    ptr_inc;

  assign req_edge   = trocar_req & ~prev_req_q;
  assign ponto_edge = ponto_in & ~prev_ponto_q;
  assign grant_mask = N_LANES'(1) << grant_q;
  assign ptr_inc    = {1'b0, list_ptr_q} + (ADDR_W+1)'(1);

  rr_arbiter #(.N(N_LANES)) u_arb (
    .req (pending_q),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Saturating add of every simultaneous hit this cycle.
  always_comb begin
    score_sum = {1'b0, score_q};
    for (int i = 0; i < N_LANES; i++)
      score_sum = score_sum + (SCORE_W+1)'(ponto_edge[i]);
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    prev_req_d   = trocar_req;
    prev_ponto_d = ponto_in;
    cmd_load_d   = '0;
    cmd_out_d    = CMD_W'(CMD_NONE);
    score_d      = score_q;
    list_ptr_d   = list_ptr_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    unique case (state_q)
      S_IDLE: begin
        pending_d = '0;
        if (start) begin
          state_d    = S_ARB;
          score_d    = '0;
          list_ptr_d = '0;
          rr_ptr_d   = '0;
        end
      end
      S_ARB: begin
        pending_d = pending_q | req_edge;
        score_d   = score_sat;
        if (arb_vld) begin
          grant_d = arb_idx;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pending_d  = pending_q | req_edge;
        score_d    = score_sat;
        cmd_out_d  = cmd_data;
        cmd_load_d = grant_mask;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        pending_d  = (pending_q & ~grant_mask) | req_edge;
        score_d    = score_sat;
        list_ptr_d = ptr_inc[ADDR_W-1:0];
        rr_ptr_d   = (int'(grant_q) == N_LANES-1) ? '0 : grant_q + IW'(1);
        if (ptr_inc == LAST) begin
          state_d   = S_DONE;
          pending_d = '0;
        end else begin
          state_d = S_ARB;
        end
      end
      S_DONE: begin
        pending_d = '0;
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    fim_d  = (state_d == S_DONE);
    busy_d = (state_d == S_FETCH) || (state_d == S_LOAD);
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      prev_req_q   <= '0;
      prev_ponto_q <= '0;
      cmd_load_q   <= '0;
      cmd_out_q    <= '0;
      score_q      <= '0;
      list_ptr_q   <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      fim_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      prev_req_q   <= prev_req_d;
      prev_ponto_q <= prev_ponto_d;
      cmd_load_q   <= cmd_load_d;
      cmd_out_q    <= cmd_out_d;
      score_q      <= score_d;
      list_ptr_q   <= list_ptr_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      fim_q        <= fim_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_addr    = list_ptr_q;
  assign cmd_out     = cmd_out_q;
  assign cmd_load    = cmd_load_q;
  assign score       = score_q;
  assign fim_de_jogo = fim_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Randomized bench for lane_scheduler against a transaction-level game model.
// Drives on the falling edge, checks 1 time unit after the rising edge.
module tb_lane_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] trocar_req = '0;
  logic [2:0] ponto_in = '0;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_data = '0;
  logic [3:0] cmd_out;
  logic [2:0] cmd_load;
  logic [7:0] score;
  logic       fim_de_jogo;
  logic       busy;

  logic [3:0] rom [16];

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  // Game model: which lanes wait, what is being served, how far along.
  bit       m_run, m_over;
  bit [2:0] m_pend, m_prev_r, m_prev_p, m_load;
  bit [3:0] m_out;
  int       m_score, m_served, m_last, m_g, m_since;

  lane_scheduler dut (
    .CLOCK_25    (clk),
    .rst_n       (rst_n),
    .start       (start),
    .trocar_req  (trocar_req),
    .ponto_in    (ponto_in),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_out     (cmd_out),
    .cmd_load    (cmd_load),
    .score       (score),
    .fim_de_jogo (fim_de_jogo),
    .busy        (busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cmd_data <= rom[cmd_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_over = 0; m_pend = 0;
    m_prev_r = 0; m_prev_p = 0; m_load = 0; m_out = 0;
    m_score = 0; m_served = 0; m_last = 2; m_g = 0; m_since = -1;
  endtask

  task automatic model_step(input bit [2:0] rq, input bit [2:0] pt,
                            input bit st);
    bit [2:0] e, pe;
    bit found;
    e = rq & ~m_prev_r;
    pe = pt & ~m_prev_p;
    m_prev_r = rq;
    m_prev_p = pt;
    m_load = 0;
    m_out = 0;
    if (m_over) begin
      if (st) m_over = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_score = 0; m_served = 0;
        m_last = 2; m_pend = 0; m_since = -1;
      end
    end else begin
      m_score = m_score + $countones(pe);
      if (m_score > 255) m_score = 255;
      if (m_since == -1) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && m_pend[(m_last + k) % 3]) begin
            found = 1;
            m_g = (m_last + k) % 3;
          end
        end
        if (found) m_since = 0;
        m_pend |= e;
      end else if (m_since == 0) begin
        m_since = 1;
        m_load = 3'(1 << m_g);
        m_out = rom[m_served];
        m_pend |= e;
      end else begin
        m_pend[m_g] = 0;
        m_pend |= e;
        m_served++;
        m_last = m_g;
        m_since = -1;
        if (m_served == 10) begin
          m_run = 0; m_over = 1; m_pend = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("cmd_load", cmd_load, m_load);
    chk("cmd_out", cmd_out, m_out);
    chk("score", score, m_score);
    chk("fim", fim_de_jogo, m_over);
    chk("busy", busy, m_run && m_since >= 0);
    chk("cmd_addr", cmd_addr, m_served % 16);
  endtask

  task automatic cyc(input bit [2:0] rq, input bit [2:0] pt, input bit st);
    @(negedge clk);
    trocar_req = rq;
    ponto_in = pt;
    start = st;
    @(posedge clk);
    model_step(rq, pt, st);
    #1;
    if (cmd_load != 0) n_pulse++;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'h5; rom[1] = 4'h1; rom[2] = 4'h2; rom[3] = 4'h3;
    model_reset();
    #5;
    chk("rst_load", cmd_load, 0);
    chk("rst_score", score, 0);
    chk("rst_fim", fim_de_jogo, 0);
    chk("rst_addr", cmd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on lane 0, then all three lanes together.
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b001, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(3'b000, 3'b000, 1'b0);
    chk("t1_pulses", n_pulse, 1);
    cyc(3'b111, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) cyc(3'b000, 3'b000, 1'b0);
    chk("t2_pulses", n_pulse, 4);

    // Lane 0 then lanes 0+1 together: lane 1 must come first.
    cyc(3'b001, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b011, 3'b000, 1'b0);
    for (int i = 0; i < 9; i++) cyc(3'b000, 3'b000, 1'b0);

    // Random traffic until the list is exhausted, then more in DONE.
    for (int i = 0; i < 400 && !m_over; i++)
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          m_run && ($urandom_range(0, 15) == 0));
    chk("exhausted", m_over, 1);
    chk("pulse_total", n_pulse, 10);
    for (int i = 0; i < 20; i++)
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    chk("done_pulses", n_pulse, 10);

    // Restart and drive the score into saturation.
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    chk("restart_score", score, 0);
    for (int i = 0; i < 84; i++) begin
      cyc(3'b000, 3'b111, 1'b0);
      cyc(3'b000, 3'b000, 1'b0);
    end
    cyc(3'b000, 3'b001, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b001, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    chk("score_254", score, 254);
    cyc(3'b000, 3'b011, 1'b0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b011, 1'b0);
    chk("score_sat", score, 255);

    // Reset while a lane is being loaded.
    cyc(3'b010, 3'b000, 1'b0);
    for (int i = 0; i < 10 && m_since != 1; i++)
      cyc(3'b000, 3'b000, 1'b0);
    chk("reached_load", m_since, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_load", cmd_load, 0);
    chk("rst_mid_score", score, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 6; i++) cyc(3'b000, 3'b000, 1'b0);
    chk("post_rst_pulses", n_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
